// File: rtl/enc_serializer_if.sv
// Word-in / symbol-out streaming bundle for enc_serializer.
// The slave modport is the serializer's view; the master modport is the source/sink side.
interface enc_serializer_if #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned SYM_W       = 2,
    parameter int unsigned FRAME_WORDS = 4
);
    localparam int unsigned POS_W = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [SYM_W-1:0]  out_sym;
    logic              out_first;
    logic              out_last;
    logic [POS_W-1:0]  frame_pos;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sym, out_first, out_last, frame_pos
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sym, out_first, out_last, frame_pos
    );
endinterface

// File: rtl/enc_serializer.sv
// Unpacks 16-bit convolutional-code words into 2-bit symbols (symbol k = bits [2k+1:2k]),
// through a 2-word FIFO, with per-word first and per-frame last markers.
module enc_serializer #(
    parameter int unsigned WORD_W      = 16,
    parameter int unsigned SYM_W       = 2,
    parameter int unsigned FRAME_WORDS = 4
) (
    input  logic             clk,
    input  logic             rst,
    enc_serializer_if.slave  bus
);
    localparam int unsigned SYMS   = WORD_W / SYM_W;
    localparam int unsigned SIDX_W = (SYMS > 1) ? $clog2(SYMS) : 1;
    localparam int unsigned POS_W  = (FRAME_WORDS > 1) ? $clog2(FRAME_WORDS) : 1;

    localparam logic [SIDX_W-1:0] LAST_SYM = SIDX_W'(SYMS - 1);
    localparam logic [POS_W-1:0]  LAST_POS = POS_W'(FRAME_WORDS - 1);
    localparam logic [1:0]        FULL     = 2'd2;

    // Registered state
    logic [WORD_W-1:0] mem [2];
    logic              wr_ptr;
    logic              rd_ptr;
    logic [1:0]        count;
    logic [SIDX_W-1:0] sym_idx;
    logic [POS_W-1:0]  frame_pos;

    // Next-state values
    logic [WORD_W-1:0] mem_nxt [2];
    logic              wr_ptr_nxt;
    logic              rd_ptr_nxt;
    logic [1:0]        count_nxt;
    logic [SIDX_W-1:0] sym_idx_nxt;
    logic [POS_W-1:0]  frame_pos_nxt;

    // Handshake decodes; in_ready depends only on registered count
    logic              in_ready_c;
    logic              out_valid_c;
    logic              push_c;
    logic              beat_c;
    logic              pop_c;
    logic [WORD_W-1:0] head_c;
    logic [SYM_W-1:0]  syms_c [SYMS];

    assign in_ready_c  = (count != FULL);
    assign out_valid_c = (count != 2'd0);
    assign push_c      = bus.in_valid & in_ready_c;
    assign beat_c      = out_valid_c & bus.out_ready;
    assign pop_c       = beat_c & (sym_idx == LAST_SYM);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            mem[0]    <= '0;
            mem[1]    <= '0;
            wr_ptr    <= 1'b0;
            rd_ptr    <= 1'b0;
            count     <= 2'd0;
            sym_idx   <= '0;
            frame_pos <= '0;
        end else begin
            mem[0]    <= mem_nxt[0];
            mem[1]    <= mem_nxt[1];
            wr_ptr    <= wr_ptr_nxt;
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            sym_idx   <= sym_idx_nxt;
            frame_pos <= frame_pos_nxt;
        end
    end

    // Next-state logic: push writes at wr_ptr, the eighth beat of a word pops it
    always_comb begin
        mem_nxt[0]    = mem[0];
        mem_nxt[1]    = mem[1];
        wr_ptr_nxt    = wr_ptr;
        rd_ptr_nxt    = rd_ptr;
        count_nxt     = count;
        sym_idx_nxt   = sym_idx;
        frame_pos_nxt = frame_pos;

        if (push_c) begin
            mem_nxt[wr_ptr] = bus.in_data;
            wr_ptr_nxt      = ~wr_ptr;
        end

        if (beat_c) begin
            if (pop_c) begin
                sym_idx_nxt   = '0;
                rd_ptr_nxt    = ~rd_ptr;
                frame_pos_nxt = (frame_pos == LAST_POS) ? '0 : POS_W'(frame_pos + 1'b1);
            end else begin
                sym_idx_nxt = SIDX_W'(sym_idx + 1'b1);
            end
        end

        case ({push_c, pop_c})
            2'b10:   count_nxt = 2'(count + 2'd1);
            2'b01:   count_nxt = 2'(count - 2'd1);
            default: count_nxt = count;
        endcase
    end

    // Symbol slicing of the head word
    assign head_c = mem[rd_ptr];

    for (genvar g = 0; g < SYMS; g++) begin : g_slice
        assign syms_c[g] = head_c[g*SYM_W +: SYM_W];
    end

    assign bus.in_ready  = in_ready_c;
    assign bus.out_valid = out_valid_c;
    assign bus.out_sym   = out_valid_c ? syms_c[sym_idx] : '0;
    assign bus.out_first = out_valid_c & (sym_idx == '0);
    assign bus.out_last  = out_valid_c & (sym_idx == LAST_SYM) & (frame_pos == LAST_POS);
    assign bus.frame_pos = frame_pos;
endmodule

// File: doc/enc_serializer.md
# enc_serializer

Converts 16-bit packed convolutional-code words back into a stream of 2-bit code symbols, one symbol per accepted output beat. It undoes the packing done by `enc_paralleler`, which places symbol k in bits [2k+1:2k]. It sits between a word-wide encoded-data source and any symbol-serial consumer, such as a channel model or a serial Viterbi front end. Both sides use valid/ready handshakes, with a 2-word buffer in between.

## Interface
- WORD_W, 16, input word width; must equal SYM_W × 8
- SYM_W, 2, symbol width (rate-1/2 code pair)
- FRAME_WORDS, 4, words per frame; frame position drives `out_last`
- clk  input  1  single clock; all state updates on posedge
- rst  input  1  asynchronous, active-low reset
- in_valid  input  1  `in_data` is valid
- in_ready  output  1  buffer can accept a word this cycle
- in_data  input  WORD_W  packed word; symbol k is in bits [2k+1:2k]
- out_valid  output  1  `out_sym` is valid
- out_ready  input  1  consumer takes the symbol this cycle
- out_sym  output  SYM_W  current symbol; 2'b00 when `out_valid`=0
- out_first  output  1  current symbol is symbol 0 of its word
- out_last  output  1  current symbol is symbol 7 of the last word of a frame
- frame_pos  output  clog2(FRAME_WORDS)  index of the head word within its frame

## Operation
- **Storage.** 2-entry circular FIFO of words. State is `wr_ptr`, `rd_ptr` (1 bit each), `count` (0..2), symbol index `sym_idx` (3 bits) and frame counter `frame_pos`.
- **Input side.**
  - `in_ready` = (`count` != 2), decoded from registered state only. There is no combinational path from `out_ready`.
  - A push occurs when `in_valid` & `in_ready`. The word is written at `wr_ptr`, then `wr_ptr` toggles.
  - `in_data` is ignored when there is no push.
- **Output side.**
  - `out_valid` = (`count` != 0).
  - `out_sym` = `mem[rd_ptr][2*sym_idx+1 : 2*sym_idx]` when valid, otherwise 2'b00.
  - `out_first` = `out_valid` & (`sym_idx`==0).
  - `out_last` = `out_valid` & (`sym_idx`==7) & (`frame_pos`==FRAME_WORDS-1).
- **Beat.** A beat occurs when `out_valid` & `out_ready`.
  - If `sym_idx` < 7: `sym_idx` increments.
  - If `sym_idx` == 7: this is a pop. `sym_idx` goes to 0, `rd_ptr` toggles, and `frame_pos` increments, wrapping from FRAME_WORDS-1 to 0.
- **Count update.** `count` += push, −= pop.
  - A simultaneous push and pop leaves `count` unchanged; this is legal only when `count` is 1 (at 2, `in_ready`=0; at 0, no pop is possible).
  - At `count`=2 a pop frees space, but `in_ready` rises only in the following cycle.
- **Stall.** With `out_ready`=0, `out_sym`, `out_first`, `out_last` and `sym_idx` hold stable, and the data stays stable while `out_valid` is high.
- **Reset.** Asserting `rst` low at any time, including mid-word, immediately clears:
  - `count`, both pointers, `sym_idx`, `frame_pos` and both storage entries to 0;
  - the outputs: `out_valid`=0, `out_sym`=0, `out_first`=0, `out_last`=0, `frame_pos`=0, `in_ready`=1.
  - A partially emitted word is discarded. There are no spurious beats after release.

## Timing
- **Latency.** A word pushed at edge N into an empty FIFO gives `out_valid`=1 with symbol 0 in the cycle after edge N. Symbol k appears after the k-th following beat.
- **Throughput.** With `out_ready` held at 1, one symbol per cycle and 8 cycles per word.
- **Gapless streaming.** With a second word already buffered, symbol 0 of word 2 follows symbol 7 of word 1 with no gap cycle.
- **Backpressure.** A source offering one word every 8 cycles never sees `in_ready`=0 while `out_ready`=1. A source that is faster sees `in_ready`=0 after 2 words are buffered.
- **Counter wraps.** `sym_idx` wraps 7→0 and `frame_pos` wraps FRAME_WORDS-1→0 on the same pop edge.

## Test plan
- **Reset state.** Drive `rst`=0 and sample → `in_ready`=1, `out_valid`=0, `out_sym`=00, `out_first`=0, `out_last`=0, `frame_pos`=0.
- **Symbol order.** Push 16'hE4B1 with `out_ready`=1 → symbols 01,00,11,10,00,01,10,11 on 8 consecutive cycles; `out_first` only on the first symbol; then `out_valid`=0.
- **Backpressure.** Push 3 words back-to-back with `out_ready`=0 → `in_ready`=0 after 2 pushes and the 3rd word is not accepted. Raise `out_ready` → 16 symbols with no gap. `in_ready` returns 1 the cycle after the first pop.
- **Stall hold.** Push 16'h1B1B and toggle `out_ready` 1,0,0,1,… → `out_sym` holds during stalls. Sequence is 11,10,01,00,11,10,01,00, with no symbol lost or duplicated.
- **Frame marking.** Stream 9 words with FRAME_WORDS=4 → `out_last` pulses on symbol 7 of words 4 and 8 only; `frame_pos` reads 0 during word 9.
- **Reset mid-word.** Assert `rst` low after 3 beats of a word, then release and push 16'hFFFF → output starts at symbol 0 (11); `frame_pos`=0; no residual symbols from the aborted word.
